// File: rtl/mm_result_wb_buffer.sv
// Result write-back buffer: deskews the per-column MXU result stream into whole
// rows and writes each completed row to RAM as one line over a valid/ready handshake.
module mm_result_wb_buffer #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lsu_mm_wb_ctrl_start,
    input  logic [3:0]           lsu_mm_wb_ctrl_row_len,
    input  logic [3:0]           lsu_mm_wb_ctrl_col_len,
    input  logic [11:0]          lsu_mm_wb_ctrl_start_addr,
    input  logic [LANES-1:0]     mxu_lsu_wb_vld,
    input  logic [8*LANES-1:0]   mxu_lsu_wb_data,
    output logic                 lsu_mm_wb_ram_write_vld,
    input  logic                 lsu_mm_wb_ram_write_rdy,
    output logic [ADDR_W-1:0]    lsu_mm_wb_ram_write_addr,
    output logic [8*LANES-1:0]   lsu_mm_wb_ram_write_data,
    output logic [LANES-1:0]     lsu_mm_wb_ram_write_mask,
    output logic                 lsu_mm_wb_busy,
    output logic                 lsu_mm_wb_done,
    output logic                 lsu_mm_wb_ovf
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          row_len_q, row_len_d;
    logic [3:0]          col_len_q, col_len_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [4:0]          lane_ptr_q [LANES];
    logic [4:0]          lane_ptr_d [LANES];
    logic [4:0]          wr_ptr_q, wr_ptr_d;
    logic                ovf_q, ovf_d;
    logic                write_vld_q, write_vld_d;
    logic [LANES-1:0]    cap;
    logic                hs, last_hs;
    logic [7:0]          ent_q [LANES][LANES];
    logic                unused_addr_bits;

    // Only line-aligned addresses are supported; the byte offset is discarded.
    assign unused_addr_bits = ^lsu_mm_wb_ctrl_start_addr[3:0];

    assign hs      = write_vld_q & lsu_mm_wb_ram_write_rdy;
    assign last_hs = hs & (wr_ptr_q == {1'b0, row_len_q});

    always_comb begin
        state_d    = state_q;
        row_len_d  = row_len_q;
        col_len_d  = col_len_q;
        base_d     = base_q;
        lane_ptr_d = lane_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        ovf_d      = ovf_q;
        cap        = '0;
        if (lsu_mm_wb_ctrl_start) begin
            // A start always wins, including over an in-flight operation (abort).
            row_len_d = lsu_mm_wb_ctrl_row_len;
            col_len_d = lsu_mm_wb_ctrl_col_len;
            base_d    = lsu_mm_wb_ctrl_start_addr[ADDR_W+3:4];
            for (int unsigned c = 0; c < LANES; c++) lane_ptr_d[c] = '0;
            wr_ptr_d  = '0;
            ovf_d     = 1'b0;
            state_d   = S_ACTIVE;
        end else if (state_q == S_ACTIVE) begin
            for (int unsigned c = 0; c < LANES; c++) begin
                if (mxu_lsu_wb_vld[c] && (4'(c) <= col_len_q)) begin
                    if (lane_ptr_q[c] <= {1'b0, row_len_q}) begin
                        cap[c]        = 1'b1;
                        lane_ptr_d[c] = lane_ptr_q[c] + 5'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            if (hs)      wr_ptr_d = wr_ptr_q + 5'd1;
            if (last_hs) state_d  = S_IDLE;
        end
        // The last column of a row is the last byte to arrive, so its lane pointer
        // counts completed rows.
        write_vld_d = (state_d == S_ACTIVE) && (wr_ptr_d < lane_ptr_d[col_len_d]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_len_q   <= '0;
            col_len_q   <= '0;
            base_q      <= '0;
            for (int unsigned c = 0; c < LANES; c++) lane_ptr_q[c] <= '0;
            wr_ptr_q    <= '0;
            ovf_q       <= 1'b0;
            write_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_len_q   <= row_len_d;
            col_len_q   <= col_len_d;
            base_q      <= base_d;
            lane_ptr_q  <= lane_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            ovf_q       <= ovf_d;
            write_vld_q <= write_vld_d;
        end
    end

    // Entry storage needs no reset: every entry is written before it can be read.
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < LANES; c++) begin
            if (cap[c]) ent_q[lane_ptr_q[c][3:0]][c] <= mxu_lsu_wb_data[8*c +: 8];
        end
    end

    always_comb begin
        lsu_mm_wb_ram_write_data = '0;
        lsu_mm_wb_ram_write_mask = '0;
        for (int unsigned c = 0; c < LANES; c++) begin
            if (write_vld_q && (4'(c) <= col_len_q)) begin
                lsu_mm_wb_ram_write_data[8*c +: 8] = ent_q[wr_ptr_q[3:0]][c];
                lsu_mm_wb_ram_write_mask[c]        = 1'b1;
            end
        end
    end

    assign lsu_mm_wb_ram_write_vld  = write_vld_q;
    assign lsu_mm_wb_ram_write_addr = write_vld_q ? (base_q + ADDR_W'(wr_ptr_q[3:0])) : '0;
    assign lsu_mm_wb_busy           = (state_q == S_ACTIVE);
    assign lsu_mm_wb_done           = last_hs;
    assign lsu_mm_wb_ovf            = ovf_q;

endmodule

// File: tb/tb_mm_result_wb_buffer.sv
// Bench for mm_result_wb_buffer: table of skewed operations plus hand sequences
// for overflow, abort and reset; writes are checked against a scoreboard queue.
module tb_mm_result_wb_buffer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [3:0]    row_len, col_len;
    logic [11:0]   start_addr;
    logic [15:0]   mvld;
    logic [127:0]  mdata;
    logic          wvld, rdy;
    logic [7:0]    waddr;
    logic [127:0]  wdata;
    logic [15:0]   wmask;
    logic          busy, done, ovf;

    always #5 clk = ~clk;

    mm_result_wb_buffer #(.LANES(16), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_mm_wb_ctrl_start(start),
        .lsu_mm_wb_ctrl_row_len(row_len),
        .lsu_mm_wb_ctrl_col_len(col_len),
        .lsu_mm_wb_ctrl_start_addr(start_addr),
        .mxu_lsu_wb_vld(mvld),
        .mxu_lsu_wb_data(mdata),
        .lsu_mm_wb_ram_write_vld(wvld),
        .lsu_mm_wb_ram_write_rdy(rdy),
        .lsu_mm_wb_ram_write_addr(waddr),
        .lsu_mm_wb_ram_write_data(wdata),
        .lsu_mm_wb_ram_write_mask(wmask),
        .lsu_mm_wb_busy(busy),
        .lsu_mm_wb_done(done),
        .lsu_mm_wb_ovf(ovf)
    );

    typedef struct {
        int unsigned row_len, col_len, addr, hold, seed;
    } vec_t;

    typedef struct {
        logic [7:0]   addr;
        logic [127:0] data;
        logic [15:0]  mask;
        bit           last;
        bit           chk_lat;
        int unsigned  cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[6];
    int unsigned n_checks = 0, n_fail = 0;
    int unsigned done_cnt = 0, wr_cnt = 0, cyc = 0;
    logic        hold_prev = 1'b0;
    logic [7:0]  pa;
    logic [127:0] pd;
    logic [15:0] pm;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] val(input int unsigned seed, input int unsigned r, input int unsigned c);
        return 8'(16 * r + c + seed);
    endfunction

    function automatic exp_t mk(input int unsigned seed, input int unsigned r, input int unsigned rl,
                                input int unsigned cl, input int unsigned a, input bit lat,
                                input int unsigned cy);
        exp_t e;
        e.data = '0;
        e.mask = '0;
        for (int unsigned c = 0; c <= cl; c++) begin
            e.data[8*c +: 8] = val(seed, r, c);
            e.mask[c]        = 1'b1;
        end
        e.addr    = 8'((a >> 4) + r);
        e.last    = (r == rl);
        e.chk_lat = lat;
        e.cyc     = cy;
        return e;
    endfunction

    // Write monitor: payload stability under back-pressure, scoreboard, done alignment.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev && wvld) begin
                check("stable_addr", 128'(waddr), 128'(pa));
                check("stable_data", wdata, pd);
                check("stable_mask", 128'(wmask), 128'(pm));
            end
            if (wvld && rdy) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0h expected no write", waddr);
                end else begin
                    mon_e = sb.pop_front();
                    check("wr_addr", 128'(waddr), 128'(mon_e.addr));
                    check("wr_data", wdata, mon_e.data);
                    check("wr_mask", 128'(wmask), 128'(mon_e.mask));
                    check("wr_done", 128'(done), 128'(mon_e.last));
                    if (mon_e.chk_lat) check("wr_latency", 128'(cyc), 128'(mon_e.cyc));
                end
            end else begin
                check("done_no_hs", 128'(done), 128'(0));
            end
            if (done) done_cnt++;
            hold_prev = wvld && !rdy;
            pa = waddr; pd = wdata; pm = wmask;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic do_start(input int unsigned rl, input int unsigned cl, input int unsigned a);
        @(posedge clk); #1;
        start = 1'b1; row_len = 4'(rl); col_len = 4'(cl); start_addr = 12'(a);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Skewed drain: row r column c driven in cycle r+c; junk on lanes above col_len.
    task automatic drain(input int unsigned rl, input int unsigned cl, input int unsigned a,
                         input int unsigned hold, input int unsigned seed, input bit push,
                         input int unsigned tmax);
        for (int unsigned t = 0; t <= rl + cl && t < tmax; t++) begin
            mvld = '0; mdata = '0; rdy = (t >= hold);
            for (int unsigned c = 0; c < 16; c++) begin
                if (c <= cl) begin
                    if (t >= c && t - c <= rl) begin
                        mvld[c] = 1'b1;
                        mdata[8*c +: 8] = val(seed, t - c, c);
                        if (c == cl && push) sb.push_back(mk(seed, t - c, rl, cl, a, hold == 0, cyc + 1));
                    end
                end else if ($urandom_range(1, 0) == 1) begin
                    mvld[c] = 1'b1;
                    mdata[8*c +: 8] = 8'($urandom);
                end
            end
            @(posedge clk); #1;
        end
        mvld = '0; mdata = '0; rdy = 1'b1;
    endtask

    task automatic wait_done(input int unsigned target);
        int unsigned k = 0;
        while ((done_cnt < target || sb.size() != 0) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check("completion_timeout", 128'(k >= 300), 128'(0));
        @(posedge clk); #1;
        check("busy_after_done", 128'(busy), 128'(0));
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int unsigned d0, w0;

    initial begin
        vecs[0] = '{15, 15, 12'h120,  0, 0};
        vecs[1] = '{ 2,  3, 12'h050,  0, 7};
        vecs[2] = '{15, 15, 12'h120, 20, 0};
        vecs[3] = '{ 3, 15, 12'hFE0,  0, 3};
        vecs[4] = '{ 0,  0, 12'h00F,  0, 8'h5A};
        vecs[5] = '{ 5,  7, 12'h3A0,  3, 8'h21};

        rst_n = 1'b0; start = 1'b0; row_len = '0; col_len = '0; start_addr = '0;
        mvld = '0; mdata = '0; rdy = 1'b1;
        #12;
        check("rst_vld",  128'(wvld), 128'(0));
        check("rst_addr", 128'(waddr), 128'(0));
        check("rst_data", wdata, 128'(0));
        check("rst_mask", 128'(wmask), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_ovf",  128'(ovf), 128'(0));
        @(negedge clk); rst_n = 1'b1;

        for (int unsigned i = 0; i < 6; i++) begin
            d0 = done_cnt;
            w0 = wr_cnt;
            do_start(vecs[i].row_len, vecs[i].col_len, vecs[i].addr);
            check("busy_on_start", 128'(busy), 128'(1));
            drain(vecs[i].row_len, vecs[i].col_len, vecs[i].addr, vecs[i].hold, vecs[i].seed, 1'b1, 99);
            wait_done(d0 + 1);
            check("done_count", 128'(done_cnt - d0), 128'(1));
            check("write_count", 128'(wr_cnt - w0), 128'(vecs[i].row_len + 1));
            check("ovf_clean", 128'(ovf), 128'(0));
        end

        // Overflow on lane 0 and an ignored lane 5 with row_len=1, col_len=1.
        d0 = done_cnt;
        do_start(1, 1, 12'h200);
        rdy = 1'b1;
        mvld = 16'h0021; mdata = '0;
        mdata[7:0] = val(9, 0, 0); mdata[47:40] = 8'hEE;
        step(1);
        mvld = 16'h0003; mdata = '0;
        mdata[7:0] = val(9, 1, 0); mdata[15:8] = val(9, 0, 1);
        sb.push_back(mk(9, 0, 1, 1, 12'h200, 1'b0, 0));
        step(1);
        mvld = 16'h0003; mdata = '0;
        mdata[7:0] = 8'h77; mdata[15:8] = val(9, 1, 1);
        sb.push_back(mk(9, 1, 1, 1, 12'h200, 1'b0, 0));
        step(1);
        mvld = 16'h0001; mdata = '0; mdata[7:0] = 8'h88;
        step(1);
        mvld = '0; mdata = '0;
        wait_done(d0 + 1);
        check("ovf_set", 128'(ovf), 128'(1));

        // Abort: two rows written, third pending under rdy=0, then a new start.
        d0 = done_cnt;
        w0 = wr_cnt;
        do_start(3, 0, 12'h400);
        check("ovf_cleared", 128'(ovf), 128'(0));
        drain(3, 0, 12'h400, 0, 1, 1'b1, 2);
        step(3);
        check("abort_two_rows", 128'(wr_cnt - w0), 128'(2));
        rdy = 1'b0;
        mvld = 16'h0001; mdata = '0; mdata[7:0] = val(1, 2, 0);
        step(1);
        mvld = '0;
        step(1);
        check("abort_pending_vld", 128'(wvld), 128'(1));
        do_start(1, 0, 12'h410);
        check("abort_vld_dropped", 128'(wvld), 128'(0));
        rdy = 1'b1;
        drain(1, 0, 12'h410, 0, 2, 1'b1, 99);
        wait_done(d0 + 1);
        check("abort_done_count", 128'(done_cnt - d0), 128'(1));
        check("abort_write_count", 128'(wr_cnt - w0), 128'(4));

        // Reset mid-operation with a row pending.
        do_start(3, 3, 12'h600);
        drain(3, 3, 12'h600, 100, 4, 1'b0, 5);
        rdy = 1'b0;
        step(1);
        check("pre_reset_vld", 128'(wvld), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_vld",  128'(wvld), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_addr", 128'(waddr), 128'(0));
        check("mid_rst_data", wdata, 128'(0));
        check("mid_rst_mask", 128'(wmask), 128'(0));
        check("mid_rst_done", 128'(done), 128'(0));
        sb.delete();
        @(negedge clk); rst_n = 1'b1; rdy = 1'b1;
        step(2);
        check("post_rst_busy", 128'(busy), 128'(0));
        check("post_rst_vld",  128'(wvld), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
